// File: rtl/data_mem_lsu.sv
// Load/store unit over a byte-laned, resettable data memory with configurable
// wait states and a busy/ready handshake toward the memory stage.

module data_mem_lsu_lane #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];
endmodule

module data_mem_lsu #(
  parameter int size    = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            memRead,
  input  logic            memWrite,
  input  logic [2:0]      funct3,
  input  logic [size-1:0] address,
  input  logic [size-1:0] writeData,
  output logic [size-1:0] out,
  output logic            ready,
  output logic            busy,
  output logic            error
);
  localparam int AW = $clog2(DEPTH);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef struct packed {
    logic            wr;
    logic [2:0]      f3;
    logic [size-1:0] addr;
    logic [size-1:0] wd;
  } req_t;

  state_t state;
  logic [2:0] cnt;
  req_t cap, in_req, cur;
  logic accept, complete, misalign, illegal, bad;
  logic [AW-1:0] idx;
  logic [1:0] lane;
  logic [NUM_LANES-1:0] be;
  logic [NUM_LANES-1:0][7:0] rword, wword;
  logic [size-1:0] shw, ld;
  logic unused_bits;

  assign in_req   = '{wr: memWrite, f3: funct3, addr: address, wd: writeData};
  assign accept   = (state == IDLE || state == DONE) && (memRead || memWrite);
  // A zero-latency accept completes on the same edge, so decode the live inputs then.
  assign cur      = (state == BUSY) ? cap : in_req;
  assign complete = (state == BUSY && cnt == 3'd0) || (accept && LATENCY == 0);

  assign idx  = cur.addr[AW+1:2];
  assign lane = cur.addr[1:0];
  assign unused_bits = ^cur.addr[size-1:AW+2];

  always_comb begin
    misalign = 1'b0;
    case (cur.f3[1:0])
      2'b01:   misalign = cur.addr[0];
      2'b10:   misalign = (cur.addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
    if (cur.wr) illegal = !(cur.f3 == 3'b000 || cur.f3 == 3'b001 || cur.f3 == 3'b010);
    else        illegal = (cur.f3 == 3'b011 || cur.f3 == 3'b110 || cur.f3 == 3'b111);
    bad = misalign || illegal;
  end

  // Store data is replicated across lanes; byte enables pick which lanes land.
  always_comb begin
    be    = '0;
    wword = cur.wd;
    case (cur.f3[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wword = {4{cur.wd[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << lane;
        wword = {2{cur.wd[15:0]}};
      end
      default: be = 4'b1111;
    endcase
    if (!(complete && cur.wr && !bad)) be = '0;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    data_mem_lsu_lane #(.DEPTH(DEPTH), .AW(AW)) u_lane (
      .clk   (clk),
      .reset (reset),
      .we    (be[g]),
      .idx   (idx),
      .wdata (wword[g]),
      .rdata (rword[g])
    );
  end

  always_comb begin
    shw = rword >> {lane, 3'b000};
    case (cur.f3)
      3'b000:  ld = {{24{shw[7]}}, shw[7:0]};
      3'b001:  ld = {{16{shw[15]}}, shw[15:0]};
      3'b010:  ld = rword;
      3'b100:  ld = {24'd0, shw[7:0]};
      3'b101:  ld = {16'd0, shw[15:0]};
      default: ld = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cap   <= '0;
      out   <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
      error <= 1'b0;
    end else begin
      ready <= complete;
      case (state)
        BUSY: begin
          busy <= 1'b1;
          if (cnt == 3'd0) state <= DONE;
          else             cnt   <= cnt - 3'd1;
        end
        default: begin
          if (accept) begin
            cap  <= in_req;
            busy <= 1'b1;
            if (LATENCY == 0) begin
              state <= DONE;
            end else begin
              state <= BUSY;
              cnt   <= 3'(LATENCY - 1);
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
      if (complete) begin
        error <= bad;
        if (bad)          out <= '0;
        else if (!cur.wr) out <= ld;
      end
    end
  end
endmodule
